// File: rtl/dct_transpose_buf_pkg.sv
// Shared JPEG block constants and coefficient row type.
package jpeg_pkg;
   localparam int BLOCK_SIZE = 8;
   localparam int IDX_W      = 3;
   localparam int COEF_W     = 16;

   typedef logic [BLOCK_SIZE-1:0][COEF_W-1:0] coef_row_t;

   function automatic logic idx_last(input logic [IDX_W-1:0] i);
      return i == IDX_W'(BLOCK_SIZE - 1);
   endfunction
endpackage

// File: rtl/dct_transpose_buf_if.sv
// AXI4-Stream style beat channel used between DCT stages.
interface axi4_stream_if #(
   parameter int DW = 128
) ();
   logic          tvalid;
   logic          tready;
   logic [DW-1:0] tdata;
   logic          tuser;
   logic          tlast;

   modport master (
      output tvalid, tdata, tuser, tlast,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tuser, tlast,
      output tready
   );
endinterface

// File: rtl/dct_transpose_buf_bank.sv
// One 8x8 coefficient array: row-wide write, combinational column read.
module transpose_bank
   import jpeg_pkg::*;
#(
   parameter int COEF_WIDTH = COEF_W
) (
   input  logic                                    clk_i,
   input  logic                                    i_we,
   input  logic [IDX_W-1:0]                        i_row,
   input  logic [BLOCK_SIZE-1:0][COEF_WIDTH-1:0]   i_wdata,
   input  logic [IDX_W-1:0]                        i_col,
   output logic [BLOCK_SIZE-1:0][COEF_WIDTH-1:0]   o_cdata
);
   logic [BLOCK_SIZE-1:0][COEF_WIDTH-1:0] r_mem [BLOCK_SIZE];

   always_ff @(posedge clk_i) begin
      if (i_we) begin
         r_mem[i_row] <= i_wdata;
      end
   end

   always_comb begin
      o_cdata = '0;
      for (int r = 0; r < BLOCK_SIZE; r++) begin
         o_cdata[r] = r_mem[r][i_col];
      end
   end
endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose between row and column DCT passes.
module dct_transpose_buf
   import jpeg_pkg::*;
#(
   parameter int COEF_WIDTH = COEF_W
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   axi4_stream_if.slave  row_i,
   axi4_stream_if.master col_o
);
   typedef logic [BLOCK_SIZE-1:0][COEF_WIDTH-1:0] row_t;

   logic [1:0]       r_full;
   logic [1:0]       r_usr;
   logic [1:0]       r_lst;
   logic             r_wr_bank;
   logic             r_rd_bank;
   logic [IDX_W-1:0] r_wr_row;
   logic [IDX_W-1:0] r_rd_col;

   logic [1:0]       w_full_nxt;
   logic             w_wr_hs;
   logic             w_rd_hs;
   logic             w_wr_done;
   logic             w_rd_done;
   row_t             w_cdata [2];

   assign w_wr_hs   = row_i.tvalid && !r_full[r_wr_bank];
   assign w_rd_hs   = r_full[r_rd_bank] && col_o.tready;
   assign w_wr_done = w_wr_hs && idx_last(r_wr_row);
   assign w_rd_done = w_rd_hs && idx_last(r_rd_col);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      transpose_bank #(
         .COEF_WIDTH (COEF_WIDTH)
      ) u_bank (
         .clk_i   (clk_i),
         .i_we    (w_wr_hs && (r_wr_bank == 1'(b))),
         .i_row   (r_wr_row),
         .i_wdata (row_i.tdata),
         .i_col   (r_rd_col),
         .o_cdata (w_cdata[b])
      );
   end

   // Fill and drain always target different banks, so both may apply.
   always_comb begin
      w_full_nxt = r_full;
      if (w_wr_done) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
      if (w_rd_done) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_full    <= '0;
         r_usr     <= '0;
         r_lst     <= '0;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         r_wr_row  <= '0;
         r_rd_col  <= '0;
      end else begin
         r_full <= w_full_nxt;
         if (w_wr_hs) begin
            r_wr_row <= r_wr_row + 1'b1;
            if (r_wr_row == '0) begin
               r_usr[r_wr_bank] <= row_i.tuser;
               r_lst[r_wr_bank] <= row_i.tlast;
            end else begin
               r_lst[r_wr_bank] <= r_lst[r_wr_bank] | row_i.tlast;
            end
            if (w_wr_done) begin
               r_wr_bank <= !r_wr_bank;
            end
         end
         if (w_rd_hs) begin
            r_rd_col <= r_rd_col + 1'b1;
            if (w_rd_done) begin
               r_rd_bank <= !r_rd_bank;
            end
         end
      end
   end

   assign row_i.tready = !r_full[r_wr_bank];
   assign col_o.tvalid = r_full[r_rd_bank];
   assign col_o.tdata  = w_cdata[r_rd_bank];
   assign col_o.tuser  = r_usr[r_rd_bank] && (r_rd_col == '0);
   assign col_o.tlast  = r_lst[r_rd_bank] && idx_last(r_rd_col);
endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for the 8x8 ping-pong transpose buffer.
module tb_dct_transpose_buf;
   import jpeg_pkg::*;

   localparam int W  = 16;
   localparam int DW = W * 8;

   typedef struct {
      logic [DW-1:0] d;
      logic          u;
      logic          l;
   } beat_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   bit   rnd = 1'b0;
   int   errs = 0;
   int   checks = 0;
   beat_t q[$];

   always #5 clk = ~clk;

   axi4_stream_if #(.DW(DW)) row_if ();
   axi4_stream_if #(.DW(DW)) col_if ();

   dct_transpose_buf #(
      .COEF_WIDTH (W)
   ) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .row_i  (row_if),
      .col_o  (col_if)
   );

   task automatic chk(input string n, input logic [DW-1:0] a,
                      input logic [DW-1:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && col_if.tvalid) begin
         if (q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL spurious_beat: got %h expected none",
                     col_if.tdata);
         end else begin
            chk("col_data", col_if.tdata, q[0].d);
            chk("col_user", DW'(col_if.tuser), DW'(q[0].u));
            chk("col_last", DW'(col_if.tlast), DW'(q[0].l));
            if (col_if.tready) void'(q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      if (rnd) begin
         #1 col_if.tready = 1'($urandom_range(1));
      end
   end

   function automatic logic [W-1:0] val(int kind, int b, int r, int c);
      logic [W-1:0] v;
      case (kind)
         0: v = W'(16 * r + c);
         1: v = W'((b << 8) | (16 * r + c));
         default: begin
            case ((r + c) % 4)
               0: v = 16'h8000;
               1: v = W'(-2048);
               2: v = W'(-(r * 8 + c + 1 + b));
               default: v = W'(16'h7fff ^ b);
            endcase
         end
      endcase
      return v;
   endfunction

   function automatic logic [DW-1:0] mkrow(int kind, int b, int r);
      logic [DW-1:0] d = '0;
      for (int c = 0; c < 8; c++) d[c*W +: W] = val(kind, b, r, c);
      return d;
   endfunction

   function automatic void push_block(int kind, int b, logic u,
                                      logic [7:0] lm);
      beat_t bt;
      for (int c = 0; c < 8; c++) begin
         bt.d = '0;
         for (int r = 0; r < 8; r++) bt.d[r*W +: W] = val(kind, b, r, c);
         bt.u = u && (c == 0);
         bt.l = (|lm) && (c == 7);
         q.push_back(bt);
      end
   endfunction

   task automatic send_row(input logic [DW-1:0] d, input logic u,
                           input logic l, output bit first);
      bit hs = 1'b0;
      int n = 0;
      first = 1'b0;
      row_if.tvalid = 1'b1;
      row_if.tdata  = d;
      row_if.tuser  = u;
      row_if.tlast  = l;
      while (!hs && n < 200) begin
         @(negedge clk);
         hs = row_if.tready;
         if (n == 0) first = hs;
         @(posedge clk);
         #1;
         n++;
      end
      if (!hs) begin
         checks++;
         errs++;
         $display("FAIL row_timeout: got tready=0 expected handshake");
      end
   endtask

   task automatic send_block(input int kind, input int b, input logic u,
                             input logic [7:0] lm, output int stalls);
      bit f;
      stalls = 0;
      push_block(kind, b, u, lm);
      for (int r = 0; r < 8; r++) begin
         send_row(mkrow(kind, b, r), u && r == 0, lm[r], f);
         if (!f) stalls++;
      end
   endtask

   task automatic idle();
      row_if.tvalid = 1'b0;
      row_if.tuser  = 1'b0;
      row_if.tlast  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", DW'(q.size()), '0);
      repeat (3) @(negedge clk);
      chk("idle_valid", DW'(col_if.tvalid), '0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int st;
      int tot;
      bit f;
      idle();
      row_if.tdata  = '0;
      col_if.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", DW'(col_if.tvalid), '0);
      chk("rst_user", DW'(col_if.tuser), '0);
      chk("rst_last", DW'(col_if.tlast), '0);
      chk("rst_ready", DW'(row_if.tready), DW'(1));
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // single block, latency of first column
      push_block(0, 0, 1'b1, 8'h00);
      for (int r = 0; r < 8; r++) begin
         if (r == 7) chk("pre_valid", DW'(col_if.tvalid), '0);
         send_row(mkrow(0, 0, r), r == 0, 1'b0, f);
      end
      idle();
      chk("lat_valid", DW'(col_if.tvalid), DW'(1));
      drain();

      // four blocks back to back
      tot = 0;
      for (int b = 0; b < 4; b++) begin
         send_block(1, b, b[0], 8'h00, st);
         tot += st;
      end
      idle();
      chk("b2b_stalls", DW'(tot), '0);
      drain();

      // backpressure with three blocks
      col_if.tready = 1'b0;
      send_block(1, 4, 1'b1, 8'h00, st);
      send_block(1, 5, 1'b0, 8'h00, st);
      idle();
      @(negedge clk);
      chk("bp_ready", DW'(row_if.tready), '0);
      chk("bp_valid", DW'(col_if.tvalid), DW'(1));
      @(posedge clk);
      #1;
      fork
         begin
            send_block(1, 6, 1'b1, 8'h80, st);
            idle();
         end
         begin
            repeat (10) @(posedge clk);
            #1 col_if.tready = 1'b1;
         end
      join
      drain();

      // random output ready, negative coefficients
      rnd = 1'b1;
      for (int b = 0; b < 3; b++) begin
         send_block(2, b, 1'b1, (b == 1) ? 8'h80 : 8'h00, st);
      end
      idle();
      drain();
      rnd = 1'b0;
      @(posedge clk);
      #2 col_if.tready = 1'b1;

      // tlast on row 7 of block 2 only
      for (int b = 0; b < 3; b++) begin
         send_block(1, 8 + b, b == 0, (b == 2) ? 8'h80 : 8'h00, st);
      end
      idle();
      drain();

      // reset with one full block and a partial one pending
      col_if.tready = 1'b0;
      send_block(1, 12, 1'b1, 8'h80, st);
      for (int r = 0; r < 5; r++) send_row(mkrow(1, 13, r), 1'b0, 1'b0, f);
      idle();
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      q.delete();
      col_if.tready = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", DW'(col_if.tvalid), '0);
      chk("mid_rst_ready", DW'(row_if.tready), DW'(1));
      @(posedge clk);
      #1;
      send_block(1, 14, 1'b1, 8'h00, st);
      idle();
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
